axi4_lite_line_writeback_seq: RTL and testbench

- Controller that sequences a full cache-line write-back through the single-word axi4_lite_master_write.
- Latches one line plus its base address, then issues WORDS_PER_LINE single-beat writes in ascending address order.
- Each word waits for the master's completion before the next is issued; the first error response aborts the sequence.
- Sits between the data-cache write-back path (requester side) and axi4_lite_master_write (master side).

---
 rtl/axi4_lite_line_writeback_seq_pkg.sv | 20 ++
 rtl/axi4_lite_line_writeback_seq.sv | 110 +++++++++++
 tb/tb_axi4_lite_line_writeback_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_line_writeback_seq_pkg.sv
// Shared types and geometry helpers for the cache-line write-back sequencer.
package axi4_lite_line_writeback_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } t_wb_state;

    function automatic int unsigned bpw(input int unsigned dw);
        return dw / 8;
    endfunction

    // Number of low address bits covered by one line.
    function automatic int unsigned off_width(input int unsigned dw, input int unsigned wpl);
        return $clog2(wpl * (dw / 8));
    endfunction

endpackage

// File: rtl/axi4_lite_line_writeback_seq.sv
// Sequences one cache line as WORDS_PER_LINE single-beat writes through
// axi4_lite_master_write, aborting on the first error response.
module axi4_lite_line_writeback_seq
    import axi4_lite_line_writeback_seq_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned WORDS_PER_LINE = 16
) (
    input  logic                                   clk,
    input  logic                                   arst,
    input  logic                                   i_wb_start,
    input  logic [AXI_ADDR_WIDTH-1:0]              i_wb_addr,
    input  logic [AXI_DATA_WIDTH*WORDS_PER_LINE-1:0] i_wb_line,
    output logic                                   o_wb_busy,
    output logic                                   o_wb_done,
    output logic                                   o_wb_fault,
    output logic [AXI_ADDR_WIDTH-1:0]              o_addr,
    output logic [AXI_DATA_WIDTH-1:0]              o_data,
    output logic                                   o_start_write,
    input  logic                                   i_done,
    input  logic                                   i_write_fault
);

    localparam int unsigned AW   = AXI_ADDR_WIDTH;
    localparam int unsigned DW   = AXI_DATA_WIDTH;
    localparam int unsigned WPL  = WORDS_PER_LINE;
    localparam int unsigned LW   = DW * WPL;
    localparam int unsigned BPW  = bpw(DW);
    localparam int unsigned OFFW = off_width(DW, WPL);
    localparam int unsigned IDXW = $clog2(WPL);

    localparam logic [AW-1:0]   ALIGN_MASK = {{(AW-OFFW){1'b1}}, {OFFW{1'b0}}};
    localparam logic [AW-1:0]   ADDR_STEP  = AW'(BPW);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(WPL - 1);

    t_wb_state       state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   line_q, line_d;
    logic            fault_q, fault_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            fault_q <= fault_d;
        end
    end

    // addr_q tracks base + idx*BPW incrementally, so it wraps modulo 2^AW.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        line_d  = line_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (i_wb_start) begin
                    addr_d  = i_wb_addr & ALIGN_MASK;
                    line_d  = i_wb_line;
                    idx_d   = '0;
                    fault_d = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_done) begin
                    if (i_write_fault) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = START;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status strobes decode directly from the state flops (Moore).
    assign o_start_write = (state_q == START);
    assign o_wb_busy     = (state_q != IDLE);
    assign o_wb_done     = (state_q == DONE);
    assign o_wb_fault    = (state_q == DONE) && fault_q;
    assign o_addr        = addr_q;
    assign o_data        = line_q[DW*int'(idx_q) +: DW];

endmodule

// File: tb/tb_axi4_lite_line_writeback_seq.sv
// Randomized scoreboard bench for the line write-back sequencer with a
// behavioural master model answering each single-word write.
module tb_axi4_lite_line_writeback_seq;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned WPL = 16;
    localparam int unsigned LW  = DW * WPL;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          arst;
    logic          i_wb_start;
    logic [AW-1:0] i_wb_addr;
    logic [LW-1:0] i_wb_line;
    logic          o_wb_busy;
    logic          o_wb_done;
    logic          o_wb_fault;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_start_write;
    logic          i_done;
    logic          i_write_fault;

    axi4_lite_line_writeback_seq #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .i_wb_start   (i_wb_start),
        .i_wb_addr    (i_wb_addr),
        .i_wb_line    (i_wb_line),
        .o_wb_busy    (o_wb_busy),
        .o_wb_done    (o_wb_done),
        .o_wb_fault   (o_wb_fault),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_start_write(o_start_write),
        .i_done       (i_done),
        .i_write_fault(i_write_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t exp_wr[$];
    bit  exp_done[$];
    int  checks        = 0;
    int  failures      = 0;
    int  master_starts = 0;
    int  fault_target  = -1;
    int  fixed_lat     = 0;
    int  done_cnt      = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < int'(WPL); k++) r[k*DW +: DW] = $urandom;
        return r;
    endfunction

    // Master model: answers each start after a latency, faulting on the targeted start.
    initial begin
        int lat;
        bit f;
        i_done        = 1'b0;
        i_write_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (o_start_write === 1'b1) begin
                f = (master_starts == fault_target);
                master_starts++;
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
                repeat (lat) @(posedge clk);
                #1 i_done = 1'b1;
                i_write_fault = f;
                @(posedge clk);
                #1 i_done = 1'b0;
                i_write_fault = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or a completion.
    initial begin
        logic [AW-1:0] cap_a;
        logic [DW-1:0] cap_d;
        bit            have_cap;
        bit            prev_idone;
        wr_t           e;
        bit            ef;
        have_cap   = 1'b0;
        prev_idone = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                have_cap   = 1'b0;
                prev_idone = 1'b0;
            end else begin
                if (o_start_write) begin
                    check("start_busy", AW'(o_wb_busy), AW'(1));
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start actual=%h expected=none", o_addr);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", o_addr, e.addr);
                        check("wr_data", AW'(o_data), AW'(e.data));
                    end
                    cap_a    = o_addr;
                    cap_d    = o_data;
                    have_cap = 1'b1;
                end else if (i_done && have_cap && o_wb_busy) begin
                    check("hold_addr", o_addr, cap_a);
                    check("hold_data", AW'(o_data), AW'(cap_d));
                    have_cap = 1'b0;
                end
                if (o_wb_done) begin
                    done_cnt++;
                    check("done_latency", AW'(prev_idone), AW'(1));
                    check("done_busy", AW'(o_wb_busy), AW'(1));
                    if (exp_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=%0b expected=none", o_wb_fault);
                    end else begin
                        ef = exp_done.pop_front();
                        check("done_fault", AW'(o_wb_fault), AW'(ef));
                    end
                end
                prev_idone = i_done;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  AW'(o_wb_busy), '0);
        check({tag, "_done"},  AW'(o_wb_done), '0);
        check({tag, "_fault"}, AW'(o_wb_fault), '0);
        check({tag, "_start"}, AW'(o_start_write), '0);
        check({tag, "_addr"},  o_addr, '0);
        check({tag, "_data"},  AW'(o_data), '0);
    endtask

    // Issues one request; the reference model derives the expected writes from the line rules.
    task automatic do_req(input logic [AW-1:0] base, input logic [LW-1:0] line,
                          input int fault_at, input bit pulse_mid, input bit do_reset);
        logic [AW-1:0] al;
        int cnt, d0, s0, n;
        wr_t w;
        @(posedge clk);
        #1;
        al  = base & ~64'h3F;
        cnt = (fault_at < 0) ? int'(WPL) : fault_at + 1;
        for (int k = 0; k < cnt; k++) begin
            w.addr = al + AW'(k * 4);
            w.data = line[k*DW +: DW];
            exp_wr.push_back(w);
        end
        exp_done.push_back(fault_at >= 0);
        fault_target = (fault_at < 0) ? -1 : master_starts + fault_at;
        s0 = master_starts;
        d0 = done_cnt;
        i_wb_start = 1'b1;
        i_wb_addr  = base;
        i_wb_line  = line;
        @(posedge clk);
        #1;
        i_wb_start = 1'b0;
        i_wb_addr  = {$urandom, $urandom};
        i_wb_line  = rand_line();
        if (do_reset) begin
            n = 0;
            while (master_starts < s0 + 8 && n < 2000) begin
                @(negedge clk);
                #2;
                n++;
            end
            check("reset_reach_idx7", AW'(master_starts >= s0 + 8), AW'(1));
            @(negedge clk);
            #1 arst = 1'b1;
            #1 check_all_zero("midrst");
            exp_wr.delete();
            exp_done.delete();
            repeat (2) @(posedge clk);
            #1 arst = 1'b0;
            repeat (10) @(posedge clk);
            return;
        end
        if (pulse_mid) begin
            repeat (20) @(posedge clk);
            #1 i_wb_start = 1'b1;
            check("mid_busy", AW'(o_wb_busy), AW'(1));
            @(posedge clk);
            #1 i_wb_start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done");
        end
        check("leftover_writes", AW'(exp_wr.size()), '0);
        check("leftover_dones", AW'(exp_done.size()), '0);
        @(negedge clk);
        check("idle_after_done", AW'(o_wb_busy), '0);
        check("done_one_cycle", AW'(o_wb_done), '0);
    endtask

    initial begin
        logic [LW-1:0] l;
        arst       = 1'b1;
        i_wb_start = 1'b0;
        i_wb_addr  = '0;
        i_wb_line  = '0;
        #12 check_all_zero("reset");
        @(posedge clk);
        #1 arst = 1'b0;
        repeat (2) @(posedge clk);

        // Reference line at an aligned base with a fixed 4-cycle master.
        for (int k = 0; k < int'(WPL); k++) l[k*DW +: DW] = 32'hA000_0000 + DW'(k);
        fixed_lat = 4;
        do_req(64'h0000_0000_1000_0040, l, -1, 1'b0, 1'b0);
        fixed_lat = 0;

        do_req(64'h0000_0000_1000_0057, rand_line(), -1, 1'b0, 1'b0);
        do_req({$urandom, $urandom}, rand_line(), 4, 1'b0, 1'b0);
        do_req({$urandom, $urandom}, rand_line(), -1, 1'b0, 1'b0);
        do_req(64'hFFFF_FFFF_FFFF_FFC0, rand_line(), -1, 1'b1, 1'b0);
        do_req({$urandom, $urandom}, rand_line(), -1, 1'b0, 1'b1);
        do_req({$urandom, $urandom}, rand_line(), -1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            do_req({$urandom, $urandom}, rand_line(),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WPL - 1)) : -1,
                   1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
